// File: rtl/gated_vco_sfx.sv
// Trigger-gated VCO sound-effect voice: slewed level, modulated VCO,
// decaying envelope and diode-halved output high-pass.
`timescale 1ns/1ps
module gated_vco_sfx #(
  parameter int WIDTH              = 16,
  parameter int PHASE_BITS         = 24,
  parameter int TRIG_LEVEL         = 6826,
  parameter int SLEW_STEP          = 21,
  parameter int MOD_HALF_PERIOD    = 24,
  parameter int MOD_AMPLITUDE      = 2000,
  parameter int CV_LP_SHIFT        = 3,
  parameter int BASE_INC           = 65536,
  parameter int CV_GAIN            = 8,
  parameter int ENV_SHIFT          = 9,
  parameter int OUT_HP_SHIFT       = 6,
  parameter int ONE_SHOT           = 0,
  parameter int HOLD_SAMPLES       = 4800,
  parameter int RETRIGGER          = 1,
  parameter int TRIGGER_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  input  logic                    audio_clk_en,
  input  logic                    trigger,
  output logic                    busy,
  output logic signed [WIDTH-1:0] out
);

  localparam int HCW =
    (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int MCW =
    (MOD_HALF_PERIOD > 1) ? $clog2(MOD_HALF_PERIOD) : 1;
  localparam int PB = PHASE_BITS;

  typedef logic signed [WIDTH-1:0] smp_t;
  typedef logic signed [WIDTH+1:0] wide_t;
  typedef logic signed [PB:0]      inc_t;
  typedef enum logic [1:0] {IDLE, ON, HOLD} state_t;

  localparam wide_t SMAX = wide_t'(2**(WIDTH-1) - 1);
  localparam wide_t SMIN = wide_t'(-(2**(WIDTH-1)));
  localparam wide_t SLEW = wide_t'(SLEW_STEP);
  localparam smp_t  LVL_ON = smp_t'(TRIG_LEVEL);
  localparam smp_t  MOD_P  = smp_t'(MOD_AMPLITUDE);
  localparam smp_t  MOD_N  = smp_t'(-MOD_AMPLITUDE);
  localparam inc_t  BASE_S = inc_t'(BASE_INC);
  localparam inc_t  GAIN_S = inc_t'(CV_GAIN);
  localparam inc_t  INC_MIN = inc_t'(1);
  localparam inc_t  INC_MAX = inc_t'(2**(PB-1) - 1);
  localparam logic [HCW-1:0] HOLD_LOAD =
    HCW'(HOLD_SAMPLES - 1);
  localparam logic [MCW-1:0] MOD_LAST =
    MCW'(MOD_HALF_PERIOD - 1);

  function automatic smp_t sat(input wide_t v);
    smp_t r;
    if (v > SMAX)      r = smp_t'(SMAX);
    else if (v < SMIN) r = smp_t'(SMIN);
    else               r = smp_t'(v);
    return r;
  endfunction

  state_t         state_q, state_d;
  logic           trig, trig_q, rise, gate;
  logic [HCW-1:0] hold_q, hold_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic           msq_q, msq_d;
  logic [PB-1:0]  phase_q, phase_d;
  smp_t lvl_q, lvl_d, cv_q, cv_d, cvlp_q, cvlp_d;
  smp_t lvlp_q, lvlp_d, env_q, env_d;
  smp_t g_q, g_d, glp_q, glp_d, out_q, out_d;
  smp_t tgt, mod, y;
  wide_t lvl_diff;
  inc_t inc_raw, inc_clamped;

  assign trig = trigger ^ (TRIGGER_ACTIVE_LOW != 0);
  assign rise = trig & ~trig_q;
  assign gate = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (ONE_SHOT != 0) begin
          if (rise) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end else if (trig) begin
          state_d = ON;
        end
      end
      ON:   if (!trig) state_d = IDLE;
      HOLD: begin
        // a reload beats expiry, so HOLD is kept
        if (rise && RETRIGGER != 0) hold_d = HOLD_LOAD;
        else if (hold_q == '0)      state_d = IDLE;
        else                        hold_d = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tgt = gate ? LVL_ON : '0;
    lvl_diff = wide_t'(tgt) - wide_t'(lvl_q);
    if (lvl_diff > SLEW)
      lvl_d = smp_t'(wide_t'(lvl_q) + SLEW);
    else if (lvl_diff < -SLEW)
      lvl_d = smp_t'(wide_t'(lvl_q) - SLEW);
    else
      lvl_d = tgt;

    mcnt_d = (mcnt_q == MOD_LAST) ? '0 : mcnt_q + 1'b1;
    msq_d  = msq_q ^ (mcnt_q == MOD_LAST);
    mod    = msq_q ? MOD_P : MOD_N;

    cv_d   = sat(wide_t'(lvl_q) + wide_t'(mod));
    cvlp_d = smp_t'(wide_t'(cvlp_q) +
      ((wide_t'(cv_q) - wide_t'(cvlp_q)) >>> CV_LP_SHIFT));

    inc_raw = BASE_S + inc_t'(cvlp_q) * GAIN_S;
    if (inc_raw < INC_MIN)      inc_clamped = INC_MIN;
    else if (inc_raw > INC_MAX) inc_clamped = INC_MAX;
    else                        inc_clamped = inc_raw;
    phase_d = phase_q + PB'(inc_clamped);

    lvlp_d = smp_t'(wide_t'(lvlp_q) +
      ((wide_t'(lvl_q) - wide_t'(lvlp_q)) >>> ENV_SHIFT));
    env_d  = sat(wide_t'(lvl_q) - wide_t'(lvlp_q));
    g_d    = phase_q[PB-1] ? env_q : '0;

    glp_d = smp_t'(wide_t'(glp_q) +
      ((wide_t'(g_q) - wide_t'(glp_q)) >>> OUT_HP_SHIFT));
    y     = sat(wide_t'(g_q) - wide_t'(glp_q));
    // negative half-wave is halved, like a diode clamp
    out_d = (y > 0) ? y : (y >>> 1);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      hold_q  <= '0;
      mcnt_q  <= '0;
      msq_q   <= 1'b0;
      phase_q <= '0;
      lvl_q   <= '0;
      cv_q    <= '0;
      cvlp_q  <= '0;
      lvlp_q  <= '0;
      env_q   <= '0;
      g_q     <= '0;
      glp_q   <= '0;
      out_q   <= '0;
    end else if (audio_clk_en) begin
      state_q <= state_d;
      trig_q  <= trig;
      hold_q  <= hold_d;
      mcnt_q  <= mcnt_d;
      msq_q   <= msq_d;
      phase_q <= phase_d;
      lvl_q   <= lvl_d;
      cv_q    <= cv_d;
      cvlp_q  <= cvlp_d;
      lvlp_q  <= lvlp_d;
      env_q   <= env_d;
      g_q     <= g_d;
      glp_q   <= glp_d;
      out_q   <= out_d;
    end
  end

  assign busy = gate;
  assign out  = out_q;

endmodule
